ibex_irq_ctrl: RTL and testbench

IBEX_IRQ_CTRL -- requirements
Module: ibex_irq_ctrl

---
 rtl/ibex_pkg.sv | 35 +++
 rtl/prim_flop_2sync.sv | 40 ++++
 rtl/ibex_irq_ctrl.sv | 141 ++++++++++++++
 tb/tb_ibex_irq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types and constants for the interrupt front end: privilege levels,
// the mip/mie bit layout, interrupt cause codes and the request FSM states.
package ibex_pkg;

   typedef logic [1:0] priv_lvl_e;
   localparam priv_lvl_e PRIV_LVL_U = 2'b00;
   localparam priv_lvl_e PRIV_LVL_S = 2'b01;
   localparam priv_lvl_e PRIV_LVL_H = 2'b10;
   localparam priv_lvl_e PRIV_LVL_M = 2'b11;

   typedef struct packed {
      logic        irq_software;
      logic        irq_timer;
      logic        irq_external;
      logic [14:0] irq_fast;
   } irqs_t;

   typedef logic [5:0] exc_cause_e;
   localparam exc_cause_e EXC_CAUSE_IRQ_SOFTWARE_M = {1'b1, 5'd3};
   localparam exc_cause_e EXC_CAUSE_IRQ_TIMER_M    = {1'b1, 5'd7};
   localparam exc_cause_e EXC_CAUSE_IRQ_EXTERNAL_M = {1'b1, 5'd11};
   localparam exc_cause_e EXC_CAUSE_IRQ_FAST_0     = {1'b1, 5'd16};
   localparam exc_cause_e EXC_CAUSE_IRQ_NM         = {1'b1, 5'd31};

   typedef logic [1:0] irq_state_e;
   localparam irq_state_e IRQ_IDLE = 2'd0;
   localparam irq_state_e IRQ_REQ  = 2'd1;
   localparam irq_state_e IRQ_GAP  = 2'd2;

   // Fast interrupt causes follow on contiguously from fast[0].
   function automatic exc_cause_e fast_cause(input int unsigned idx);
      return EXC_CAUSE_IRQ_FAST_0 + 6'(idx);
   endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Multi-stage synchronizer for a vector of asynchronous level signals.
// Each bit is synchronized independently; no cross-bit coherence is implied.
module prim_flop_2sync #(
   parameter int Width     = 1,
   parameter int NumStages = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] stage_d [NumStages];
   logic [Width-1:0] stage_q [NumStages];

   always_comb begin
      stage_d[0] = d_i;
      for (int i = 1; i < NumStages; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // NOTE: non-blocking assignments make every stage sample the previous
   // stage's old value, which is what turns this into a shift chain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: every stage is reset so no stale level survives into the core.
         for (int i = 0; i < NumStages; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumStages; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q_o = stage_q[NumStages-1];

endmodule

// File: rtl/ibex_irq_ctrl.sv
// Interrupt front end: synchronizes the interrupt lines, latches NMI edges,
// arbitrates by fixed priority and presents one registered request at a time.
module ibex_irq_ctrl
   import ibex_pkg::*;
#(
   parameter int SyncStages = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        irq_software_i,
   input  logic        irq_timer_i,
   input  logic        irq_external_i,
   input  logic [14:0] irq_fast_i,
   input  logic        irq_nm_i,
   input  irqs_t       mie_i,
   input  logic        mstatus_mie_i,
   input  priv_lvl_e   priv_lvl_i,
   input  logic        debug_mode_i,
   input  logic        irq_ack_i,
   input  logic        mret_i,
   output irqs_t       irq_pending_o,
   output logic        irq_req_o,
   output exc_cause_e  irq_cause_o,
   output logic        nmi_mode_o
);

   logic [18:0] irq_raw;
   logic [18:0] irq_sync;
   logic        nmi_sync;
   logic [17:0] irq_enabled;
   logic        global_en;
   logic        nmi_edge;
   logic        nmi_eligible;
   logic        sel_valid;
   exc_cause_e  sel_cause;
   logic        cause_still_eligible;
   logic        nmi_ack;

   irq_state_e  state_d, state_q;
   exc_cause_e  cause_d, cause_q;
   logic        nmi_prev_d, nmi_prev_q;
   logic        nmi_pending_d, nmi_pending_q;
   logic        nmi_mode_d, nmi_mode_q;

   assign irq_raw = {irq_nm_i, irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};

   prim_flop_2sync #(
      .Width     (19),
      .NumStages (SyncStages)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (irq_raw),
      .q_o    (irq_sync)
   );

   assign nmi_sync      = irq_sync[18];
   assign irq_pending_o = irq_sync[17:0];

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      nmi_edge     = nmi_sync & ~nmi_prev_q;
      global_en    = (priv_lvl_i != PRIV_LVL_M) || mstatus_mie_i;
      irq_enabled  = irq_sync[17:0] & mie_i & {18{global_en & ~debug_mode_i}};
      nmi_eligible = (nmi_pending_q | nmi_edge) & ~debug_mode_i & ~nmi_mode_q;
      sel_valid    = 1'b1;
      sel_cause    = EXC_CAUSE_IRQ_SOFTWARE_M;

      if (nmi_eligible)        sel_cause = EXC_CAUSE_IRQ_NM;
      else if (irq_enabled[15]) sel_cause = EXC_CAUSE_IRQ_EXTERNAL_M;
      else if (irq_enabled[17]) sel_cause = EXC_CAUSE_IRQ_SOFTWARE_M;
      else if (irq_enabled[16]) sel_cause = EXC_CAUSE_IRQ_TIMER_M;
      else if (|irq_enabled[14:0]) begin
         // Walk downwards so the lowest-numbered fast line wins.
         for (int i = 14; i >= 0; i--) begin
            if (irq_enabled[i]) sel_cause = fast_cause(i);
         end
      end else begin
         sel_valid = 1'b0;
      end
   end

   always_comb begin
      cause_still_eligible = ((cause_q == EXC_CAUSE_IRQ_EXTERNAL_M) && irq_enabled[15]) ||
                             ((cause_q == EXC_CAUSE_IRQ_SOFTWARE_M) && irq_enabled[17]) ||
                             ((cause_q == EXC_CAUSE_IRQ_TIMER_M)    && irq_enabled[16]);
      for (int i = 0; i < 15; i++) begin
         if ((cause_q == fast_cause(i)) && irq_enabled[i]) cause_still_eligible = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      nmi_ack = 1'b0;
      case (state_q)
         IRQ_IDLE: begin
            if (sel_valid) begin
               state_d = IRQ_REQ;
               cause_d = sel_cause;
            end
         end
         IRQ_REQ: begin
            // An ack in the same cycle as a withdrawal still counts as taken.
            if (irq_ack_i) begin
               state_d = IRQ_GAP;
               nmi_ack = (cause_q == EXC_CAUSE_IRQ_NM);
            end else if ((cause_q != EXC_CAUSE_IRQ_NM) && !cause_still_eligible) begin
               state_d = IRQ_IDLE;
            end
         end
         IRQ_GAP: state_d = IRQ_IDLE;
         default: state_d = IRQ_IDLE;
      endcase

      nmi_prev_d    = nmi_sync;
      nmi_pending_d = nmi_ack ? 1'b0 : (nmi_pending_q | nmi_edge);
      nmi_mode_d    = nmi_ack ? 1'b1 : (mret_i ? 1'b0 : nmi_mode_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IRQ_IDLE;
         cause_q       <= EXC_CAUSE_IRQ_SOFTWARE_M;
         nmi_prev_q    <= 1'b0;
         nmi_pending_q <= 1'b0;
         nmi_mode_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cause_q       <= cause_d;
         nmi_prev_q    <= nmi_prev_d;
         nmi_pending_q <= nmi_pending_d;
         nmi_mode_q    <= nmi_mode_d;
      end
   end

   assign irq_req_o   = (state_q == IRQ_REQ);
   assign irq_cause_o = cause_q;
   assign nmi_mode_o  = nmi_mode_q;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Self-checking bench for ibex_irq_ctrl: a cycle model built from the
// arbitration rules, directed scenarios with literal expectations, random traffic.
module tb_ibex_irq_ctrl;
   import ibex_pkg::*;

   localparam int SYNC  = 2;
   localparam int B_NM  = 18;
   localparam int B_SW  = 17;
   localparam int B_TIM = 16;
   localparam int B_EXT = 15;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [18:0] in_vec = '0;
   logic [17:0] mie = '0;
   logic        mstatus = 1'b0;
   logic [1:0]  priv = 2'b11;
   logic        debug = 1'b0;
   logic        ack = 1'b0;
   logic        mret = 1'b0;

   irqs_t       irq_pending_o;
   logic        irq_req_o;
   exc_cause_e  irq_cause_o;
   logic        nmi_mode_o;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ibex_irq_ctrl #(.SyncStages(SYNC)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .irq_software_i (in_vec[B_SW]),
      .irq_timer_i    (in_vec[B_TIM]),
      .irq_external_i (in_vec[B_EXT]),
      .irq_fast_i     (in_vec[14:0]),
      .irq_nm_i       (in_vec[B_NM]),
      .mie_i          (mie),
      .mstatus_mie_i  (mstatus),
      .priv_lvl_i     (priv),
      .debug_mode_i   (debug),
      .irq_ack_i      (ack),
      .mret_i         (mret),
      .irq_pending_o  (irq_pending_o),
      .irq_req_o      (irq_req_o),
      .irq_cause_o    (irq_cause_o),
      .nmi_mode_o     (nmi_mode_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Sources in priority order: 0 = NMI, 1 = external, 2 = software,
   // 3 = timer, 4+i = fast[i].
   logic [18:0] hist[$];
   bit          m_req, m_gap, m_npend, m_nmode;
   logic [5:0]  m_cause;

   function automatic bit src_lvl(input logic [18:0] s, input int k);
      case (k)
         0:       return s[B_NM];
         1:       return s[B_EXT];
         2:       return s[B_SW];
         3:       return s[B_TIM];
         default: return s[k-4];
      endcase
   endfunction

   function automatic logic [5:0] src_cause(input int k);
      case (k)
         0:       return 6'h3F;
         1:       return 6'h2B;
         2:       return 6'h23;
         3:       return 6'h27;
         default: return 6'h30 + 6'(k - 4);
      endcase
   endfunction

   function automatic logic [18:0] sync_at(input int k);
      return (k < hist.size()) ? hist[k] : 19'd0;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_req = 0; m_gap = 0; m_npend = 0; m_nmode = 0;
      m_cause = 6'h23;
   endtask

   task automatic model_step();
      logic [18:0] cur, prv;
      bit          nm_edge, gate, acked_nmi, cause_ok;
      bit          elig[19];
      int          best;
      cur       = sync_at(SYNC - 1);
      prv       = sync_at(SYNC);
      nm_edge   = cur[B_NM] && !prv[B_NM];
      gate      = (priv != 2'b11) || mstatus;
      best      = -1;
      acked_nmi = 0;
      cause_ok  = 0;
      for (int k = 0; k < 19; k++) begin
         if (k == 0) elig[k] = (m_npend || nm_edge) && !debug && !m_nmode;
         else        elig[k] = src_lvl(cur, k) && src_lvl({1'b0, mie}, k) && gate && !debug;
         if (elig[k] && best < 0) best = k;
         if (elig[k] && src_cause(k) == m_cause) cause_ok = 1;
      end
      if (m_req) begin
         if (ack) begin
            m_req = 0; m_gap = 1;
            acked_nmi = (m_cause == 6'h3F);
         end else if (m_cause != 6'h3F && !cause_ok) begin
            m_req = 0;
         end
      end else if (m_gap) begin
         m_gap = 0;
      end else if (best >= 0) begin
         m_req = 1;
         m_cause = src_cause(best);
      end
      m_npend = acked_nmi ? 1'b0 : (m_npend || nm_edge);
      m_nmode = acked_nmi ? 1'b1 : (mret ? 1'b0 : m_nmode);
      hist.push_front(in_vec);
      if (hist.size() > SYNC + 1) void'(hist.pop_back());
   endtask

   // Single compare process: advance the model on each edge, check #1 later.
   always @(posedge clk) begin
      if (!rst_ni) model_reset();
      else         model_step();
      #1;
      check("model_req",     irq_req_o,          m_req);
      check("model_cause",   irq_cause_o,        m_cause);
      check("model_nmode",   nmi_mode_o,         m_nmode);
      check("model_pending", irq_pending_o,      sync_at(SYNC - 1) & 19'h3FFFF);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic quiesce();
      in_vec = '0; mie = '0; mstatus = 0; debug = 0; priv = 2'b11;
      ack = 1; step();
      ack = 0; mret = 1; step();
      mret = 0;
      repeat (6) step();
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #2 rst_ni = 1;
      check("rst_req",   irq_req_o,     0);
      check("rst_cause", irq_cause_o,   6'h23);
      check("rst_nmode", nmi_mode_o,    0);
      check("rst_pend",  irq_pending_o, 0);

      // Timer: request on third edge, dropped after ack.
      mie[B_TIM] = 1; mstatus = 1; in_vec[B_TIM] = 1;
      step(); step();
      check("t1_pend_c2", irq_pending_o[B_TIM], 1);
      check("t1_req_c2",  irq_req_o, 0);
      step();
      check("t1_req_c3",  irq_req_o, 1);
      check("t1_cause",   irq_cause_o, 6'h27);
      ack = 1; step(); ack = 0;
      check("t1_ack_drop", irq_req_o, 0);
      quiesce();

      // External beats fast[3]; fast[3] follows once external is gone.
      mie[B_EXT] = 1; mie[3] = 1; mstatus = 1;
      in_vec[B_EXT] = 1; in_vec[3] = 1;
      repeat (3) step();
      check("t2_req",   irq_req_o, 1);
      check("t2_cause", irq_cause_o, 6'h2B);
      ack = 1; in_vec[B_EXT] = 0; step(); ack = 0;
      check("t2_gap", irq_req_o, 0);
      step(); step();
      check("t2_req_fast",   irq_req_o, 1);
      check("t2_cause_fast", irq_cause_o, 6'h33);
      quiesce();

      // NMI pulse with interrupts globally disabled; nested NMI waits for mret.
      in_vec[B_NM] = 1; step(); in_vec[B_NM] = 0;
      step(); step();
      check("t3_req",   irq_req_o, 1);
      check("t3_cause", irq_cause_o, 6'h3F);
      ack = 1; step(); ack = 0;
      check("t3_nmode", nmi_mode_o, 1);
      check("t3_gap",   irq_req_o, 0);
      in_vec[B_NM] = 1; step(); in_vec[B_NM] = 0;
      repeat (6) step();
      check("t3_blocked",     irq_req_o, 0);
      check("t3_nmode_held",  nmi_mode_o, 1);
      mret = 1; step(); mret = 0;
      check("t3_mret_nmode",  nmi_mode_o, 0);
      check("t3_mret_noreq",  irq_req_o, 0);
      step();
      check("t3_req2",   irq_req_o, 1);
      check("t3_cause2", irq_cause_o, 6'h3F);
      ack = 1; step(); ack = 0;
      check("t3_nmode2", nmi_mode_o, 1);
      mret = 1; step(); mret = 0;
      quiesce();

      // Software withdrawn before ack, then withdrawal racing an ack.
      mie[B_SW] = 1; mstatus = 1; in_vec[B_SW] = 1;
      repeat (3) step();
      check("t4_req",   irq_req_o, 1);
      check("t4_cause", irq_cause_o, 6'h23);
      in_vec[B_SW] = 0;
      step(); step();
      check("t4_hold",     irq_req_o, 1);
      step();
      check("t4_withdraw", irq_req_o, 0);
      in_vec[B_SW] = 1;
      repeat (3) step();
      check("t4_req2", irq_req_o, 1);
      in_vec[B_SW] = 0;
      step(); step();
      ack = 1; step(); ack = 0;
      check("t4_acked", irq_req_o, 0);
      step();
      check("t4_idle",  irq_req_o, 0);
      quiesce();

      // Debug mode masks NMI and timer; NMI goes first once released.
      debug = 1; mie[B_TIM] = 1; mstatus = 1; in_vec[B_TIM] = 1; in_vec[B_NM] = 1;
      step(); in_vec[B_NM] = 0;
      repeat (6) step();
      check("t5_dbg_noreq", irq_req_o, 0);
      debug = 0; step();
      check("t5_req",   irq_req_o, 1);
      check("t5_cause", irq_cause_o, 6'h3F);
      ack = 1; step(); ack = 0;
      check("t5_nmode", nmi_mode_o, 1);
      step(); step();
      check("t5_req_timer",   irq_req_o, 1);
      check("t5_cause_timer", irq_cause_o, 6'h27);

      // Reset while presenting a request with an NMI handler active.
      #3 rst_ni = 0;
      #1;
      check("t6_async_req",   irq_req_o, 0);
      check("t6_async_nmode", nmi_mode_o, 0);
      check("t6_async_pend",  irq_pending_o, 0);
      step(); rst_ni = 1;
      step(); step();
      check("t6_wait", irq_req_o, 0);
      step();
      check("t6_rereq",  irq_req_o, 1);
      check("t6_recause", irq_cause_o, 6'h27);
      quiesce();

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 99) < 8) in_vec[$urandom_range(0, 18)] ^= 1'b1;
         ack  = ($urandom_range(0, 3) == 0);
         mret = ($urandom_range(0, 15) == 0);
         if (debug) begin
            if ($urandom_range(0, 4) == 0) debug = 0;
         end else if ($urandom_range(0, 59) == 0) begin
            debug = 1;
         end
         if ($urandom_range(0, 31) == 0) mie = 18'($urandom);
         if ($urandom_range(0, 31) == 0) mstatus = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 63) == 0) priv = 2'($urandom_range(0, 3));
         if (c % 1000 == 999) begin
            rst_ni = 0; step(); rst_ni = 1;
         end
         step();
      end
      ack = 0; mret = 0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
